shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one N-bit left barrel shifter between REQS requesters.
- Round-robin arbitration across requesters.
- Valid/ready handshake on every request port and on the single response port.
- Registered one-entry response stage; result is tagged with the winning requester ID.
- Sits between client engines and the combinational shifter datapath.

Parameters:
- N, 8, data width; power of two, >= 2.
- REQS, 4, number of requesters; >= 2.
- IDW, $clog2(REQS), requester ID width (derived, not overridden).
- AW, $clog2(N), shift amount width (derived, not overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  REQS  per-requester request valid.
- req_ready  output  REQS  per-requester accept; at most one bit high per cycle.
- req_data  input  REQS*N  packed operands; requester i uses bits [i*N +: N].
- req_amt  input  REQS*AW  packed shift amounts; requester i uses bits [i*AW +: AW].
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accept.
- rsp_data  output  N  shifted result: req_data << req_amt, zero-filled, truncated to N bits.
- rsp_id  output  IDW  index of the requester that produced rsp_data.
- busy  output  1  equals rsp_valid; exported for the status register.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0.
  - req_ready is combinationally all-zero while rst_n=0.
- can_accept = !rsp_valid | rsp_ready.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo REQS.
  - The first set bit wins.
  - req_ready[win] = can_accept; all other req_ready bits are 0.
  - If no req_valid is set, no grant and req_ready=0.
- Acceptance occurs when req_valid[win] & req_ready[win] in cycle t.
  - The winner's operand and amount drive the shifter in cycle t.
  - At the edge: rsp_data <= shifted result, rsp_id <= win, rsp_valid <= 1, rr_ptr <= (win+1) mod REQS.
  - Latency: exactly one cycle, accept at t -> rsp_valid at t+1.
- Drain without new accept: if rsp_valid & rsp_ready and no acceptance, rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Back-to-back: drain and accept in the same cycle. rsp_valid stays 1 and the new result replaces the old one. Full throughput is one op/cycle.
- Backpressure: while rsp_valid & !rsp_ready, rsp_data and rsp_id stay stable, req_ready=0, and rr_ptr does not move.
- rr_ptr advances only on an accepted grant. Idle cycles never move it.
- Fairness: a continuously asserted request is granted within REQS accepted transactions.
- Requesters must hold req_data, req_amt and req_valid until accepted. The block does not check this.
- Shift amount 0 passes data unchanged. Amount N-1 leaves only bit 0 of the input, in the MSB.
- Wrap-around: a winner at index REQS-1 sets rr_ptr to 0.
- Reset mid-operation: a pending result is discarded without handshake (rsp_valid forced to 0) and rr_ptr returns to 0.

Decomposition:
- Package shift_arb_pkg holds:
  - default constants N_DEF=8 and REQS_DEF=4;
  - function rr_pick(valid, ptr) returning the index and a found flag.
- Natural sub-module: rr_arbiter (REQS-wide).
  - Inputs: valid vector, advance strobe.
  - Outputs: one-hot grant, grant index.
  - Owns rr_ptr.
- Top-level contents:
  - instantiates rr_arbiter and the existing barrelShifter datapath (N parameter passed through);
  - operand mux;
  - response register.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, then release with all req_valid=0 -> rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=4'b0000 for 5 cycles.
- Single op: req_valid=4'b0100, data[2]=8'h1B, amt[2]=3 -> req_ready=4'b0100 on the same cycle; next cycle rsp_valid=1, rsp_data=8'hD8, rsp_id=2.
- Round-robin, all four valid with rsp_ready=1, data[i]=8'h01, amt[i]=i -> grants in order 0,1,2,3,0; responses 8'h01,8'h02,8'h04,8'h08,8'h01 on consecutive cycles.
- Backpressure: rsp_ready=0 for 4 cycles after a grant with data 8'hFF, amt 7 -> rsp_data=8'h80 stays stable, req_ready=0, rr_ptr unchanged; the next grant follows rsp_ready=1 in the same cycle.
- Wrap and skip: rr_ptr=3 with req_valid=4'b0011 -> requester 0 granted, then requester 1; requester 3 absent does not stall.
- Reset mid-operation: with rsp_valid=1 and rsp_ready=0, assert rst_n=0 for 1 cycle -> rsp_valid=0 next cycle; a fresh request from requester 1 after reset is granted before requester 2.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared constants and the round-robin pick helper for shift_arbiter.
// rr_pick works on a fixed maximum width so one function serves every REQS.
package shift_arb_pkg;

    localparam int N_DEF     = 8;
    localparam int REQS_DEF  = 4;
    localparam int MAX_REQS  = 64;
    localparam int PICK_IDXW = 8;

    typedef struct packed {
        logic                 found;
        logic [PICK_IDXW-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[reqs-1:0], searching upward from ptr and wrapping.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQS-1:0] valid,
                                         input int unsigned         ptr,
                                         input int unsigned         reqs);
        rr_pick_t    res;
        int unsigned j;
        res.found = 1'b0;
        res.idx   = '0;
        j         = 32'd0;
        for (int unsigned i = 0; i < MAX_REQS; i++) begin
            if (!res.found && (i < reqs)) begin
                j = ptr + i;
                if (j >= reqs) begin
                    j = j - reqs;
                end else begin
                    j = j;
                end
                if (valid[j]) begin
                    res.found = 1'b1;
                    res.idx   = j[PICK_IDXW-1:0];
                end else begin
                    res.found = res.found;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/barrelShifter.sv
// Combinational logarithmic left shifter: zero fill, result truncated to N bits.
module barrelShifter #(
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  data_i,
    input  logic [AW-1:0] amt_i,
    output logic [N-1:0]  data_o
);

    logic [N-1:0] stage_s [0:AW];

    assign stage_s[0] = data_i;

    // Stage k shifts by 2**k when amount bit k is set.
    for (genvar k = 0; k < AW; k++) begin : g_stage
        assign stage_s[k+1] = amt_i[k] ? (stage_s[k] << (2 ** k)) : stage_s[k];
    end

    assign data_o = stage_s[AW];

endmodule

// File: rtl/shift_arbiter_rr.sv
// Round-robin arbiter: owns the rotating priority pointer, which moves
// one past the winner only when the grant is actually taken.
module rr_arbiter
    import shift_arb_pkg::*;
#(
    parameter  int REQS = REQS_DEF,
    localparam int IDW  = $clog2(REQS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [REQS-1:0] valid_i,
    input  logic            advance_i,
    output logic [REQS-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            found_o
);

    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      ptr_d;
    logic [MAX_REQS-1:0] valid_ext_s;
    rr_pick_t            pick_s;
    logic [IDW-1:0]      win_s;
    logic                unused_pick_s;

    // Widen the request vector to the helper's fixed width and pick a winner.
    always_comb begin
        valid_ext_s              = '0;
        valid_ext_s[REQS-1:0]    = valid_i;
        pick_s                   = rr_pick(valid_ext_s, 32'(ptr_q), REQS);
    end

    assign win_s         = pick_s.idx[IDW-1:0];
    assign unused_pick_s = ^pick_s.idx;
    assign found_o       = pick_s.found;
    assign grant_idx_o   = win_s;

    // One-hot grant decode of the winning index.
    always_comb begin
        grant_o = '0;
        if (pick_s.found) begin
            grant_o[win_s] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

    // Next pointer: one past the winner, wrapping at REQS-1 (REQS need not be a power of two).
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && pick_s.found) begin
            if (win_s == IDW'(REQS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_s + IDW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter among REQS requesters with round-robin arbitration
// and a one-entry registered response stage tagged with the winner's index.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter  int N    = N_DEF,
    parameter  int REQS = REQS_DEF,
    localparam int IDW  = $clog2(REQS),
    localparam int AW   = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REQS-1:0]   req_valid,
    output logic [REQS-1:0]   req_ready,
    input  logic [REQS*N-1:0] req_data,
    input  logic [REQS*AW-1:0] req_amt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    logic            can_accept_s;
    logic            accept_s;
    logic            found_s;
    logic [REQS-1:0] grant_s;
    logic [IDW-1:0]  win_s;
    logic [N-1:0]    sel_data_s;
    logic [AW-1:0]   sel_amt_s;
    logic [N-1:0]    shifted_s;

    logic            rsp_valid_q;
    logic            rsp_valid_d;
    logic [N-1:0]    rsp_data_q;
    logic [N-1:0]    rsp_data_d;
    logic [IDW-1:0]  rsp_id_q;
    logic [IDW-1:0]  rsp_id_d;

    assign can_accept_s = !rsp_valid_q || rsp_ready;
    assign accept_s     = rst_n && can_accept_s && found_s;

    rr_arbiter #(
        .REQS(REQS)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (req_valid),
        .advance_i  (accept_s),
        .grant_o    (grant_s),
        .grant_idx_o(win_s),
        .found_o    (found_s)
    );

    // Ready goes only to the winner, and never while in reset or stalled.
    always_comb begin
        req_ready = '0;
        if (rst_n && can_accept_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Operand mux: route the winner's operand and amount into the shifter.
    always_comb begin
        sel_data_s = '0;
        sel_amt_s  = '0;
        for (int i = 0; i < REQS; i++) begin
            if (win_s == IDW'(i)) begin
                sel_data_s = req_data[i*N +: N];
                sel_amt_s  = req_amt[i*AW +: AW];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    barrelShifter #(
        .N(N)
    ) u_shift (
        .data_i(sel_data_s),
        .amt_i (sel_amt_s),
        .data_o(shifted_s)
    );

    // Response stage next state: load on accept, drain on handshake, else hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = shifted_s;
            rsp_id_d    = win_s;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Response register; reset discards any pending result without handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = rsp_valid_q;

endmodule
